sram_like_resp: RTL and testbench

- Memory-side responder for the CPU's SRAM-like request/response bus, used for both instruction and data ports.
- Accepts requests with a req/addr_ok handshake, holds them in an in-order outstanding queue, and completes each after a fixed latency with a data_ok pulse.
- Backs a word-addressed internal memory with per-byte write strobes.
- Serves as the simulation and FPGA memory model once the core moves from zero-latency SRAM to a pipelined bus.

---
 rtl/sram_like_resp.sv | 128 ++++++++++++
 tb/tb_sram_like_resp.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_resp.sv
// sram_like_resp: memory-side responder for an SRAM-like req/addr_ok -> data_ok bus.
// Latency: data_ok exactly LATENCY cycles after acceptance when the queue is drained; in order.
// Backpressure: addr_ok drops while QDEPTH requests are outstanding (no same-cycle bypass).
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req, wr, wstrb       request valid, write select, byte-lane write enables
//   addr, wdata          byte address (word index taken from addr[DEPTH_LOG2+1:2]), write data
//   addr_ok              request accepted this cycle (combinational)
//   data_ok, rdata       completion pulse, read data (valid at data_ok of a read, then held)
module sram_like_resp #(
   parameter int DEPTH_LOG2 = 14,
   parameter int LATENCY    = 2,
   parameter int QDEPTH     = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int PW = $clog2(QDEPTH);
   localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [PW:0]   QFULL = (PW + 1)'(QDEPTH);
   localparam logic [TW-1:0] TLOAD = TW'(LATENCY - 1);

   typedef struct packed {
      logic                  wr;
      logic [3:0]            strb;
      logic [DEPTH_LOG2-1:0] idx;
      logic [31:0]           wdata;
   } ent_t;

   logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

   ent_t          q   [QDEPTH];
   logic [TW-1:0] tmr [QDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          ready;
   logic [31:0]   rdata_q;

   ent_t        head;
   logic        complete;
   logic        push;
   logic [31:0] rd_word;

   // Address bits outside the word index are deliberately ignored (aliasing).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

   assign head     = q[rd_ptr];
   assign complete = (count != '0) && (tmr[rd_ptr] == '0);
   // ready holds off acceptance until one clock edge has passed after reset release.
   assign addr_ok  = req && ready && (count < QFULL);
   assign push     = addr_ok;
   assign data_ok  = complete;

   // The memory op happens in the completion cycle; the read is taken from the
   // array combinationally so rdata is valid alongside data_ok, and rdata_q
   // keeps it afterwards until the next read completion.
   assign rd_word = mem[head.idx];
   assign rdata   = (complete && !head.wr) ? rd_word : rdata_q;

   // Queue payload: written on accept only, never needs reset.
   always_ff @(posedge clk) begin
      if (push) begin
         q[wr_ptr] <= '{wr: wr, strb: wstrb, idx: addr[DEPTH_LOG2+1:2], wdata: wdata};
      end
   end

   // Write commit at completion. count is cleared by reset, so dropped writes never land.
   always_ff @(posedge clk) begin
      if (complete && head.wr) begin
         for (int b = 0; b < 4; b++) begin
            if (head.strb[b]) begin
               mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready   <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rdata_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            tmr[i] <= '0;
         end
      end else begin
         ready <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (complete) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, complete})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
         if (complete && !head.wr) begin
            rdata_q <= rd_word;
         end
         // All timers count down in parallel; a push only ever lands in a free slot
         // because a full queue blocks acceptance.
         for (int i = 0; i < QDEPTH; i++) begin
            if (push && (wr_ptr == PW'(i))) begin
               tmr[i] <= TLOAD;
            end else if (tmr[i] != '0) begin
               tmr[i] <= tmr[i] - TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_like_resp.sv
// tb_sram_like_resp: directed scenarios plus randomized traffic against a queue/array model.
// Latency: model completion time = max(accept + LATENCY, previous completion + 1).
// Backpressure: model accepts only while fewer than QDEPTH requests are outstanding.
module tb_sram_like_resp;

   localparam int DL2 = 10;
   localparam int LAT = 4;
   localparam int QD  = 4;

   logic        clk;
   logic        resetn;
   logic        req;
   logic        wr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   sram_like_resp #(.DEPTH_LOG2(DL2), .LATENCY(LAT), .QDEPTH(QD)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .req     (req),
      .wr      (wr),
      .wstrb   (wstrb),
      .addr    (addr),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   typedef struct {
      bit          wr;
      bit [3:0]    strb;
      int unsigned idx;
      bit [31:0]   wdata;
      int          due;
   } ment_t;

   ment_t       mq[$];
   bit [31:0]   mmem[int unsigned];
   bit [31:0]   last_rd = '0;
   bit          last_known = 1'b1;
   bit          ready = 1'b0;

   int          acc_log[$];
   int          comp_log[$];
   logic [31:0] rd_log[$];

   function automatic int unsigned widx(bit [31:0] a);
      return (a >> 2) % (1 << DL2);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk1(string nm, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      bit    exp_aok;
      bit    exp_dok;
      ment_t h;
      ment_t e;
      bit [31:0] w;
      if (!resetn) begin
         mq.delete();
         ready      = 1'b0;
         last_rd    = '0;
         last_known = 1'b1;
         chk1("reset_addr_ok", addr_ok, 1'b0);
         chk1("reset_data_ok", data_ok, 1'b0);
         chk("reset_rdata", rdata, 32'h0);
      end else begin
         exp_aok = req && ready && (mq.size() < QD);
         exp_dok = (mq.size() > 0) && (mq[0].due == cyc);
         chk1("addr_ok", addr_ok, exp_aok);
         chk1("data_ok", data_ok, exp_dok);
         if (addr_ok) acc_log.push_back(cyc);
         if (data_ok) begin
            comp_log.push_back(cyc);
            rd_log.push_back(rdata);
         end
         if (exp_dok) begin
            h = mq.pop_front();
            if (h.wr) begin
               if (h.strb == 4'hf) begin
                  mmem[h.idx] = h.wdata;
               end else if (mmem.exists(h.idx)) begin
                  w = mmem[h.idx];
                  for (int b = 0; b < 4; b++)
                     if (h.strb[b]) w[8*b +: 8] = h.wdata[8*b +: 8];
                  mmem[h.idx] = w;
               end
            end else begin
               last_known = mmem.exists(h.idx);
               if (last_known) last_rd = mmem[h.idx];
            end
         end
         if (last_known) chk("rdata", rdata, last_rd);
         if (exp_aok) begin
            e.wr    = wr;
            e.strb  = wstrb;
            e.idx   = widx(addr);
            e.wdata = wdata;
            e.due   = cyc + LAT;
            if (mq.size() > 0 && mq[$].due + 1 > e.due) e.due = mq[$].due + 1;
            mq.push_back(e);
         end
         ready = 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   // All helpers start and end just after a rising edge.
   task automatic send(bit w, bit [3:0] s, bit [31:0] a, bit [31:0] d);
      bit done;
      done  = 1'b0;
      wr    = w;
      wstrb = s;
      addr  = a;
      wdata = d;
      req   = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (addr_ok === 1'b1) done = 1'b1;
         @(posedge clk);
         #1;
      end
      req = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: addr 0x%08h never accepted", a);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && mq.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      #1;
      if (mq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d requests still outstanding, required 0", mq.size());
      end
   endtask

   task automatic clear_logs();
      acc_log.delete();
      comp_log.delete();
      rd_log.delete();
   endtask

   function automatic logic [31:0] last_log();
      if (rd_log.size() == 0) return 32'hxxxxxxxx;
      return rd_log[$];
   endfunction

   function automatic bit [31:0] rand_addr();
      int unsigned pool [8] = '{0, 1, 4, 8, 16, 32'h3ff, 32'h200, 32'h10};
      int unsigned k;
      k = $urandom_range(0, 7);
      return ($urandom & 32'hffff_f000) | (pool[k] << 2) | $urandom_range(0, 3);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n;
   int exp_acc [6] = '{0, 1, 2, 3, 5, 6};
   int exp_cmp [6] = '{4, 5, 6, 7, 9, 10};

   initial begin
      resetn = 1'b1;
      req    = 1'b0;
      wr     = 1'b0;
      wstrb  = 4'h0;
      addr   = '0;
      wdata  = '0;
      #1 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk);
      #1;

      // Give every address used by random traffic a known value.
      foreach (exp_acc[i]) ; // no-op keeps exp_acc referenced before use
      begin
         int unsigned pool [8] = '{0, 1, 4, 8, 16, 32'h3ff, 32'h200, 32'h10};
         for (int i = 0; i < 8; i++) send(1'b1, 4'hf, pool[i] << 2, $urandom);
      end
      send(1'b1, 4'hf, 32'h0000_0040, 32'h0bad_f00d);
      wait_idle();

      // Single write: data_ok exactly LAT cycles after addr_ok, then read back.
      clear_logs();
      send(1'b1, 4'hf, 32'h1c00_0010, 32'hdead_beef);
      wait_idle();
      chk("s1_accepts", acc_log.size(), 1);
      chk("s1_completions", comp_log.size(), 1);
      if (acc_log.size() == 1 && comp_log.size() == 1)
         chk("s1_latency", comp_log[0] - acc_log[0], 4);
      send(1'b0, 4'h0, 32'h1c00_0010, 32'h0);
      wait_idle();
      chk("s1_readback", last_log(), 32'hdead_beef);

      // Byte strobes.
      send(1'b1, 4'b0001, 32'h1c00_0010, 32'h0000_00aa);
      send(1'b1, 4'b1000, 32'h1c00_0010, 32'h5500_0000);
      send(1'b0, 4'h0, 32'h1c00_0010, 32'h0);
      wait_idle();
      chk("s2_strobes", last_log(), 32'h55ad_beaa);

      // Ordering: read after write sees new data; read before write sees old data.
      send(1'b1, 4'hf, 32'h1c00_0020, 32'h1234_5678);
      send(1'b0, 4'h0, 32'h1c00_0020, 32'h0);
      wait_idle();
      chk("s4_raw", last_log(), 32'h1234_5678);
      clear_logs();
      send(1'b0, 4'h0, 32'h1c00_0020, 32'h0);
      send(1'b1, 4'hf, 32'h1c00_0020, 32'h9abc_def0);
      send(1'b0, 4'h0, 32'h1c00_0020, 32'h0);
      wait_idle();
      chk("s4_b2b_count", rd_log.size(), 3);
      if (rd_log.size() == 3) begin
         chk("s4_war_old", rd_log[0], 32'h1234_5678);
         chk("s4_new", rd_log[2], 32'h9abc_def0);
      end

      // Throughput and full queue: 6 reads with req held high.
      clear_logs();
      n     = 0;
      wr    = 1'b0;
      wstrb = 4'h0;
      addr  = 32'h1c00_0010;
      req   = 1'b1;
      for (int i = 0; i < 60 && n < 6; i++) begin
         @(negedge clk);
         if (addr_ok === 1'b1) n++;
         @(posedge clk);
         #1;
         if (n == 6) req = 1'b0;
      end
      req = 1'b0;
      wait_idle();
      chk("s3_accepts", acc_log.size(), 6);
      chk("s3_completions", comp_log.size(), 6);
      if (acc_log.size() == 6 && comp_log.size() == 6) begin
         for (int i = 0; i < 6; i++) begin
            chk($sformatf("s3_acc%0d", i), acc_log[i] - acc_log[0], exp_acc[i]);
            chk($sformatf("s3_cmp%0d", i), comp_log[i] - acc_log[0], exp_cmp[i]);
         end
      end

      // Reset with three requests in flight, including a write to 0x40.
      clear_logs();
      send(1'b0, 4'h0, 32'h1c00_0010, 32'h0);
      send(1'b1, 4'hf, 32'h0000_0040, 32'hcafe_f00d);
      send(1'b0, 4'h0, 32'h1c00_0010, 32'h0);
      @(posedge clk);
      #1;
      chk1("s5_dok_before", data_ok, 1'b1);
      req    = 1'b1;
      resetn = 1'b0;
      #1;
      chk1("s5_dok_drop", data_ok, 1'b0);
      chk1("s5_aok_drop", addr_ok, 1'b0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      req    = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("s5_no_late_dok", comp_log.size(), 0);
      send(1'b0, 4'h0, 32'h0000_0040, 32'h0);
      wait_idle();
      chk("s5_write_dropped", last_log(), 32'h0bad_f00d);

      // Aliasing with 2^10 words, and a write with no strobes.
      send(1'b1, 4'hf, 32'h1c00_0000, 32'ha5a5_a5a5);
      send(1'b0, 4'h0, 32'h0000_1000, 32'h0);
      wait_idle();
      chk("s6_alias", last_log(), 32'ha5a5_a5a5);
      send(1'b1, 4'h0, 32'h0000_0000, 32'h0);
      send(1'b0, 4'h0, 32'h1c00_0000, 32'h0);
      wait_idle();
      chk("s6_zero_strobe", last_log(), 32'ha5a5_a5a5);

      // Random traffic with one reset in the middle.
      for (int it = 0; it < 400; it++) begin
         req   = ($urandom_range(0, 9) < 7);
         wr    = $urandom_range(0, 1);
         wstrb = 4'($urandom);
         addr  = rand_addr();
         wdata = $urandom;
         if (it == 200) resetn = 1'b0;
         if (it == 202) resetn = 1'b1;
         @(posedge clk);
         #1;
      end
      req = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
